// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared register-file geometry and dump-reader FSM state type
// Purpose: constants shared by the register file, its read-port mux and the dump reader.
// Ports: none (package).
package regdump_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT,
        FINISH
    } regdump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - beat stream carrying {address, data} pairs out of the dump reader
// Purpose: valid/ready stream of register-file snapshot beats.
// Ports (signals):
//   out_valid  master->slave  beat present on out_addr/out_data
//   out_ready  slave->master  sink accepts the beat when out_valid && out_ready
//   out_addr   master->slave  register index of the beat
//   out_data   master->slave  captured register value
interface regfile_dump_reader_if;
    import regdump_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a window of registers through one read port and streams them out
// Purpose: on a start pulse, reads count registers from start_addr (wrapping modulo NUM_REGS),
//          emits each {address, data} pair as a stream beat, then pulses done.
// Ports:
//   clk           posedge clock
//   reset         synchronous, active-high
//   start         single-cycle request, only honoured in IDLE
//   start_addr    first register index of the walk
//   count         number of registers to read, clamped to NUM_REGS
//   rf_read_addr  registered address to the register-file read port
//   rf_read_data  combinational read data for rf_read_addr
//   dump          beat stream (master side)
//   busy          walk in progress (READ or PRESENT)
//   done          one-cycle pulse after the last beat is accepted
module regfile_dump_reader
    import regdump_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [ADDR_W:0]        count,
    output logic [ADDR_W-1:0]      rf_read_addr,
    input  logic [DATA_W-1:0]      rf_read_data,
    regfile_dump_reader_if.master  dump,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    regdump_state_t    state;
    regdump_state_t    state_next;
    logic [ADDR_W:0]   remaining;

    // Clamping here guarantees no register is visited twice in one walk.
    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] addr_inc;

    always_comb begin
        count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
        addr_inc      = (rf_read_addr == LAST_ADDR) ? '0 : rf_read_addr + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                // out_valid is always high in PRESENT, so ready alone means accept.
                if (dump.out_ready) begin
                    state_next = (remaining > ONE) ? READ : FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rf_read_addr   <= '0;
            remaining      <= '0;
            dump.out_valid <= 1'b0;
            dump.out_addr  <= '0;
            dump.out_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        rf_read_addr <= start_addr;
                        remaining    <= count_clamped;
                    end
                end
                READ: begin
                    // Value is whatever the register file holds at this edge; no atomic snapshot.
                    dump.out_data  <= rf_read_data;
                    dump.out_addr  <= rf_read_addr;
                    dump.out_valid <= 1'b1;
                end
                PRESENT: begin
                    if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                        remaining      <= remaining - ONE;
                        rf_read_addr   <= addr_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == READ) || (state == PRESENT);
        done = (state == FINISH);
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;
    import regdump_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    regfile_dump_reader_if dump_if ();

    regfile_dump_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .count        (count),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .dump         (dump_if),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Register-file model: x0 reads as zero.
    always_comb begin
        rf_read_data = (rf_read_addr == '0) ? '0 : regs[rf_read_addr];
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [ADDR_W-1:0] got_addr [$];
    logic [DATA_W-1:0] got_data [$];
    int                walk_cycles;
    int                stall_seen;
    logic              stall_ok;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_data(input int a);
        return (a == 0) ? '0 : regs[a];
    endfunction

    // Drives one walk; records beats; optional stall of one beat and an extra start mid-walk.
    task automatic run_walk(input int sa, input int cnt, input int stall_beat,
                            input int stall_len, input int restart_at);
        logic [ADDR_W-1:0] hold_addr;
        logic [ADDR_W-1:0] hold_rf;
        logic [DATA_W-1:0] hold_data;
        int   stalls;
        logic finished;
        got_addr.delete();
        got_data.delete();
        stall_ok  = 1'b1;
        stalls    = 0;
        finished  = 1'b0;
        hold_addr = '0;
        hold_rf   = '0;
        hold_data = '0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        count      = (ADDR_W+1)'(cnt);
        dump_if.out_ready = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        walk_cycles = 1;
        while (walk_cycles < 400) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            start = (walk_cycles == restart_at);
            if (dump_if.out_valid) begin
                if (got_addr.size() == stall_beat && stalls < stall_len) begin
                    if (stalls == 0) begin
                        hold_addr = dump_if.out_addr;
                        hold_data = dump_if.out_data;
                        hold_rf   = rf_read_addr;
                    end else if (dump_if.out_addr !== hold_addr || dump_if.out_data !== hold_data
                                 || rf_read_addr !== hold_rf) begin
                        stall_ok = 1'b0;
                    end
                    stalls++;
                    dump_if.out_ready = 1'b0;
                end else begin
                    dump_if.out_ready = 1'b1;
                    got_addr.push_back(dump_if.out_addr);
                    got_data.push_back(dump_if.out_data);
                end
            end else begin
                dump_if.out_ready = 1'b1;
            end
            @(negedge clk);
            walk_cycles++;
        end
        start      = 1'b0;
        stall_seen = stalls;
        check("walk_finished", 64'(finished), 64'd1);
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_beats(input string tag, input int sa, input int n);
        int ea;
        check($sformatf("%s_beats", tag), 64'(got_addr.size()), 64'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            ea = (sa + i) % NUM_REGS;
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(ea));
            check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(model_data(ea)));
        end
    endtask

    initial begin
        int   dups;
        logic seen [NUM_REGS];
        logic got_valid;
        logic spurious_done;

        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = 32'(i * 32'h11);
        end
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        dump_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(dump_if.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rf_read_addr", 64'(rf_read_addr), 64'd0);
        check("rst_out_addr", 64'(dump_if.out_addr), 64'd0);
        check("rst_out_data", 64'(dump_if.out_data), 64'd0);
        reset = 1'b0;

        // Two-register walk over preloaded values.
        regs[5] = 32'hDEADBEEF;
        regs[6] = 32'h12345678;
        run_walk(5, 2, -1, 0, -1);
        check_beats("pair", 5, 2);
        check("pair_data0_const", 64'(got_data.size() > 0 ? got_data[0] : '0), 64'hDEADBEEF);
        check("pair_data1_const", 64'(got_data.size() > 1 ? got_data[1] : '0), 64'h12345678);
        regs[5] = 32'(5 * 32'h11);
        regs[6] = 32'(6 * 32'h11);

        // Full dump with ready held high: 2 cycles per beat plus FINISH.
        run_walk(0, 32, -1, 0, -1);
        check_beats("full", 0, 32);
        check("full_cycles", 64'(walk_cycles), 64'd65);

        // Wrap and clamp.
        run_walk(30, 40, -1, 0, -1);
        check_beats("wrap", 30, 32);
        dups = 0;
        for (int i = 0; i < NUM_REGS; i++) seen[i] = 1'b0;
        foreach (got_addr[i]) begin
            if (seen[got_addr[i]]) dups++;
            seen[got_addr[i]] = 1'b1;
        end
        check("wrap_no_repeats", 64'(dups), 64'd0);

        // Backpressure on beat 1 for 10 cycles.
        run_walk(5, 4, 1, 10, -1);
        check_beats("stall", 5, 4);
        check("stall_cycles", 64'(stall_seen), 64'd10);
        check("stall_stable", 64'(stall_ok), 64'd1);

        // Zero count: no beats, done right after start is taken.
        run_walk(7, 0, -1, 0, -1);
        check("zero_beats", 64'(got_addr.size()), 64'd0);
        check("zero_done_latency", 64'(walk_cycles), 64'd1);

        // A start while busy is dropped.
        run_walk(10, 2, -1, 0, 2);
        check_beats("restart", 10, 2);

        // Reset while a beat is stalled in PRESENT.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 5'd3;
        count      = 6'd8;
        dump_if.out_ready = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        got_valid = 1'b0;
        for (int i = 0; i < 10 && !got_valid; i++) begin
            if (dump_if.out_valid) got_valid = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_present", 64'(got_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(dump_if.out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        dump_if.out_ready = 1'b1;
        spurious_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) spurious_done = 1'b1;
        end
        check("abort_no_done", 64'(spurious_done), 64'd0);
        run_walk(0, 32, -1, 0, -1);
        check_beats("after_abort", 0, 32);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
